gng_arb: RTL and testbench

Round-robin scheduler that shares one Gaussian noise datapath (uniform generator plus interpolation pipeline, fixed latency) among NUM_CH consumer channels. Issues one sample request per cycle to the datapath on behalf of an eligible channel, tags each request through a latency-matched shift register, and steers returning 16-bit s<16,11> samples into per-channel output FIFOs with valid/ready handshakes. Credit accounting guarantees no FIFO overflow, so the datapath never needs backpressure.

---
 rtl/gng_pkg.sv | 25 ++
 rtl/gng_arb_fifo.sv | 52 +++++
 rtl/gng_arb.sv | 135 +++++++++++++
 tb/tb_gng_arb.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gng_pkg.sv
// Shared definitions for the Gaussian-noise channel scheduler.
// Provides the sample width, the request tag carried alongside the datapath
// latency, and a constant clog2 helper for sizing local counters.
package gng_pkg;

  localparam int unsigned GNG_DW      = 16;
  // Tag channel field sized for the largest supported channel count (8).
  localparam int unsigned GNG_CHW_MAX = 3;

  typedef struct packed {
    logic                   vld;
    logic [GNG_CHW_MAX-1:0] ch;
  } gng_tag_t;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int unsigned gng_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/gng_arb_fifo.sv
// Single-clock per-channel sample FIFO.
// Ports: clk, rstn (sync, active-low), wr_en/wr_data push, rd_en pop
// (ignored when empty), rd_data head entry (combinational), empty, count.
// Overflow is prevented upstream by credit accounting; a write and a pop
// on a full FIFO in the same cycle is legal.
module gng_arb_fifo
  import gng_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        wr_en,
  input  logic [GNG_DW-1:0]           wr_data,
  input  logic                        rd_en,
  output logic [GNG_DW-1:0]           rd_data,
  output logic                        empty,
  output logic [gng_clog2(DEPTH):0]   count
);

  localparam int unsigned AW = gng_clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [GNG_DW-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_rd;

  assign w_rd    = rd_en && (r_count != '0);
  assign rd_data = r_mem[r_rd_ptr];
  assign empty   = (r_count == '0);
  assign count   = r_count;

  // Storage and pointers; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (wr_en) begin
        r_mem[r_wr_ptr] <= wr_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(wr_en) - CW'(w_rd);
    end
  end

endmodule

// File: rtl/gng_arb.sv
// Round-robin scheduler sharing one fixed-latency Gaussian noise datapath
// among NUM_CH consumer channels, with per-channel credits and output FIFOs.
// Ports: clk, rstn (sync, active-low); ch_en per-channel enable;
// ch_valid/ch_ready/ch_data per-channel sample handshake (16-bit each);
// dp_req request to datapath; dp_valid/dp_data datapath return;
// err_sync sticky tag/valid mismatch flag.
// Build option: define GNG_ARB_SYNCCHK_EN to enable the tag/dp_valid
// consistency check; otherwise dp_valid is ignored and err_sync is 0.
module gng_arb
  import gng_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned PIPE_LAT  = 10,
  parameter int unsigned BUF_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_CH-1:0]        ch_en,
  output logic [NUM_CH-1:0]        ch_valid,
  input  logic [NUM_CH-1:0]        ch_ready,
  output logic [NUM_CH*GNG_DW-1:0] ch_data,
  output logic                     dp_req,
  input  logic                     dp_valid,
  input  logic [GNG_DW-1:0]        dp_data,
  output logic                     err_sync
);

  localparam int unsigned CHW = gng_clog2(NUM_CH);
  localparam int unsigned CRW = gng_clog2(BUF_DEPTH + 1);
  localparam int unsigned AW  = gng_clog2(BUF_DEPTH);

  logic [CHW-1:0]            r_rr;
  logic [CRW-1:0]            r_cred [NUM_CH];
  gng_tag_t                  r_req_tag;
  gng_tag_t                  r_tag  [PIPE_LAT];

  logic [NUM_CH-1:0]         w_elig;
  logic [NUM_CH-1:0]         w_pop;
  logic [NUM_CH-1:0]         w_empty;
  logic [NUM_CH-1:0]         w_wr;
  logic [NUM_CH-1:0]         w_gnt_1h;
  logic                      w_gnt_vld;
  logic [CHW-1:0]            w_gnt_ch;
  gng_tag_t                  w_tag_out;
  logic [NUM_CH*(AW+1)-1:0]  w_cnt;

  assign ch_valid  = ~w_empty;
  assign w_pop     = ~w_empty & ch_ready;
  assign dp_req    = r_req_tag.vld;
  assign w_tag_out = r_tag[PIPE_LAT-1];

  // Eligibility and one-hot grant view per channel.
  always_comb begin
    w_elig   = '0;
    w_gnt_1h = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_elig[i]   = ch_en[i] && (r_cred[i] != '0);
      w_gnt_1h[i] = w_gnt_vld && (w_gnt_ch == CHW'(i));
    end
  end

  // First eligible channel at or after the round-robin pointer, with wrap.
  always_comb begin : p_arb
    int unsigned v_idx;
    w_gnt_vld = 1'b0;
    w_gnt_ch  = '0;
    v_idx     = 0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      v_idx = (32'(r_rr) + k) % NUM_CH;
      if (!w_gnt_vld && w_elig[CHW'(v_idx)]) begin
        w_gnt_vld = 1'b1;
        w_gnt_ch  = CHW'(v_idx);
      end
    end
  end

  // Pointer, credits, request register and latency-matched tag pipe.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rr      <= '0;
      r_req_tag <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) r_cred[i] <= CRW'(BUF_DEPTH);
      for (int unsigned k = 0; k < PIPE_LAT; k++) r_tag[k] <= '0;
    end else begin
      if (w_gnt_vld) r_rr <= CHW'((32'(w_gnt_ch) + 32'd1) % NUM_CH);
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (w_gnt_1h[i] && !w_pop[i])      r_cred[i] <= r_cred[i] - CRW'(1);
        else if (!w_gnt_1h[i] && w_pop[i]) r_cred[i] <= r_cred[i] + CRW'(1);
      end
      r_req_tag.vld <= w_gnt_vld;
      r_req_tag.ch  <= GNG_CHW_MAX'(w_gnt_ch);
      r_tag[0]      <= r_req_tag;
      for (int unsigned k = 1; k < PIPE_LAT; k++) r_tag[k] <= r_tag[k-1];
    end
  end

  // Per-channel FIFOs; writes are steered purely by the returning tag.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign w_wr[i] = w_tag_out.vld && (w_tag_out.ch == GNG_CHW_MAX'(i));

    gng_arb_fifo #(
      .DEPTH (BUF_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .wr_en   (w_wr[i]),
      .wr_data (dp_data),
      .rd_en   (w_pop[i]),
      .rd_data (ch_data[i*GNG_DW +: GNG_DW]),
      .empty   (w_empty[i]),
      .count   (w_cnt[i*(AW+1) +: (AW+1)])
    );
  end

`ifdef GNG_ARB_SYNCCHK_EN
  logic r_err;
  logic w_unused;
  assign w_unused = ^w_cnt;
  assign err_sync = r_err;

  // Sticky flag on any disagreement between returning tag and dp_valid.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_err <= 1'b0;
    end else if (w_tag_out.vld != dp_valid) begin
      r_err <= 1'b1;
    end
  end
`else
  logic w_unused;
  assign w_unused = dp_valid ^ (^w_cnt);
  assign err_sync = 1'b0;
`endif

endmodule

// File: tb/tb_gng_arb.sv
// Self-checking bench for gng_arb: a queue-based behavioural model of
// credits, round-robin order and per-channel delivery, plus a datapath
// model echoing an incrementing request counter after PIPE_LAT cycles.
module tb_gng_arb;

  localparam int NCH = 4;
  localparam int PL  = 10;
  localparam int BD  = 4;

`ifdef GNG_ARB_SYNCCHK_EN
  localparam bit SYNCCHK = 1'b1;
`else
  localparam bit SYNCCHK = 1'b0;
`endif

  logic             clk      = 1'b0;
  logic             rstn     = 1'b0;
  logic [NCH-1:0]   ch_en    = '0;
  logic [NCH-1:0]   ch_ready = '0;
  logic [NCH-1:0]   ch_valid;
  logic [NCH*16-1:0] ch_data;
  logic             dp_req;
  logic             dp_valid = 1'b0;
  logic [15:0]      dp_data  = '0;
  logic             err_sync;

  always #5 clk = ~clk;

  gng_arb #(.NUM_CH(NCH), .PIPE_LAT(PL), .BUF_DEPTH(BD)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .ch_en    (ch_en),
    .ch_valid (ch_valid),
    .ch_ready (ch_ready),
    .ch_data  (ch_data),
    .dp_req   (dp_req),
    .dp_valid (dp_valid),
    .dp_data  (dp_data),
    .err_sync (err_sync)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Behavioural model state
  typedef struct {
    int          arrive;
    int          ch;
    logic [15:0] d;
  } fl_t;
  int          m_cred [NCH];
  int          m_rr;
  bit          m_req;
  bit          m_err;
  int          m_cnt;
  fl_t         m_fl [$];
  logic [15:0] m_fifo [NCH][$];

  // Observation helpers for literal checks
  logic [15:0] obs [NCH][$];
  int          first_v [NCH];
  int          n_req;
  int          n_vseen;
  int          en_cyc;

  // Datapath model
  typedef struct packed {
    logic        v;
    logic [15:0] d;
  } dps_t;
  dps_t dp_q [$];
  int   dp_cnt = 0;
  bit   dly_arm = 1'b0;
  bit   dly_pend = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Advance the model across one clock edge using this cycle's inputs.
  task automatic model_edge();
    bit pop [NCH];
    bit gv;
    int gc;
    int idx;
    bit tagp;
    gv = 1'b0;
    gc = 0;
    tagp = 1'b0;
    if (!rstn) begin
      for (int i = 0; i < NCH; i++) begin
        m_cred[i] = BD;
        m_fifo[i].delete();
      end
      m_rr = 0; m_req = 1'b0; m_err = 1'b0; m_cnt = 0;
      m_fl.delete();
      return;
    end
    for (int i = 0; i < NCH; i++) pop[i] = (m_fifo[i].size() != 0) && ch_ready[i];
    for (int k = 0; k < NCH; k++) begin
      idx = (m_rr + k) % NCH;
      if (!gv && ch_en[idx] && m_cred[idx] > 0) begin
        gv = 1'b1;
        gc = idx;
      end
    end
    for (int i = 0; i < NCH; i++) if (pop[i]) void'(m_fifo[i].pop_front());
    while (m_fl.size() != 0 && m_fl[0].arrive == cyc) begin
      tagp = 1'b1;
      m_fifo[m_fl[0].ch].push_back(m_fl[0].d);
      void'(m_fl.pop_front());
    end
    for (int i = 0; i < NCH; i++)
      m_cred[i] = m_cred[i] + (pop[i] ? 1 : 0) - ((gv && gc == i) ? 1 : 0);
    if (gv) begin
      m_fl.push_back('{arrive: cyc + 1 + PL, ch: gc, d: 16'(m_cnt)});
      m_cnt++;
      m_rr = (gc + 1) % NCH;
    end
    m_req = gv;
    if (SYNCCHK && (dp_valid != tagp)) m_err = 1'b1;
  endtask

  task automatic compare();
    chk("dp_req", dp_req, m_req);
    chk("err_sync", err_sync, m_err);
    if (dp_req) n_req++;
    if (ch_valid != '0) n_vseen++;
    for (int i = 0; i < NCH; i++) begin
      chk($sformatf("ch_valid[%0d]", i), ch_valid[i], m_fifo[i].size() != 0);
      if (m_fifo[i].size() != 0)
        chk($sformatf("ch_data[%0d]", i), ch_data[i*16 +: 16], m_fifo[i][0]);
      if (ch_valid[i] && first_v[i] < 0) first_v[i] = cyc;
    end
  endtask

  task automatic drive_dp();
    dps_t cur;
    dps_t outp;
    if (!rstn) begin
      dp_q.delete();
      dp_cnt = 0; dp_valid = 1'b0; dp_data = '0; dly_pend = 1'b0;
      return;
    end
    cur.v = dp_req;
    cur.d = 16'(dp_cnt);
    if (dp_req) dp_cnt++;
    dp_q.push_back(cur);
    outp = '0;
    if (dp_q.size() > PL) outp = dp_q.pop_front();
    dp_valid = outp.v;
    dp_data  = outp.v ? outp.d : 16'h0;
    if (dly_pend) begin
      dp_valid = 1'b1;
      dly_pend = 1'b0;
    end else if (dly_arm && outp.v) begin
      dp_valid = 1'b0;
      dly_pend = 1'b1;
      dly_arm  = 1'b0;
    end
  endtask

  task automatic record_pops();
    for (int i = 0; i < NCH; i++)
      if (ch_valid[i] === 1'b1 && ch_ready[i]) obs[i].push_back(ch_data[i*16 +: 16]);
  endtask

  task automatic step();
    record_pops();
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    compare();
    drive_dp();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    dly_arm = 1'b0;
    step();
    rstn = 1'b1;
    chk("rst_dp_req", dp_req, 0);
    chk("rst_ch_valid", ch_valid, 0);
    chk("rst_ch_data", ch_data, 0);
    chk("rst_err_sync", err_sync, 0);
    for (int i = 0; i < NCH; i++) begin
      obs[i].delete();
      first_v[i] = -1;
    end
    n_req = 0;
    n_vseen = 0;
  endtask

  function automatic logic [15:0] obs_at(input int ch, input int j);
    if (obs[ch].size() > j) return obs[ch][j];
    return 16'hFFFF;
  endfunction

  initial begin
    do_reset();

    // Idle: nothing enabled
    repeat (50) step();
    chk("idle_req_count", n_req, 0);
    chk("idle_valid_count", n_vseen, 0);

    // All channels, consumers always ready: full rate, interleaved data
    ch_en = '1; ch_ready = '1; en_cyc = cyc; n_req = 0;
    repeat (40) step();
    chk("full_rate_reqs", n_req, 40);
    chk("first_valid_latency", first_v[0] - en_cyc, 12);
    for (int i = 0; i < NCH; i++)
      for (int j = 0; j < 3; j++)
        chk($sformatf("rr_data ch%0d #%0d", i, j), obs_at(i, j), i + 4 * j);

    // Single channel with stalled consumer: exactly BUF_DEPTH requests
    ch_en = '0; do_reset();
    ch_en = 4'b0001; ch_ready = '0;
    repeat (40) step();
    chk("stall_req_count", n_req, 4);
    chk("stall_ch0_full", ch_valid[0], 1);
    ch_ready[0] = 1'b1;
    step();
    ch_ready[0] = 1'b0; n_req = 0;
    repeat (30) step();
    chk("one_pop_one_req", n_req, 1);
    chk("one_pop_data", obs_at(0, 0), 0);

    // Two channels alternate; then drop channel 2 mid-run
    ch_en = '0; do_reset();
    ch_en = 4'b0101; ch_ready = '1;
    repeat (30) step();
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("alt ch0 #%0d", j), obs_at(0, j), 2 * j);
      chk($sformatf("alt ch2 #%0d", j), obs_at(2, j), 2 * j + 1);
    end
    ch_en = 4'b0001;
    repeat (40) step();

    // Reset with samples in flight: nothing stale afterwards, credits restored
    ch_en = '0; do_reset();
    ch_en = '1; ch_ready = '1;
    repeat (15) step();
    ch_en = '0;
    do_reset();
    repeat (30) step();
    chk("no_stale_valid", n_vseen, 0);
    ch_en = 4'b0001; ch_ready = '0; n_req = 0;
    repeat (40) step();
    chk("credits_restored", n_req, 4);

    // One dp_valid slipped by a cycle
    ch_en = '0; do_reset();
    ch_en = 4'b0001; ch_ready = '1; dly_arm = 1'b1;
    repeat (40) step();
    chk("err_after_slip", err_sync, SYNCCHK);
    repeat (10) step();
    chk("err_sticky", err_sync, SYNCCHK);
    ch_en = '0; do_reset();

    // Randomised enables and backpressure
    for (int c = 0; c < 800; c++) begin
      if (c % 40 == 0) ch_en = NCH'($urandom);
      ch_ready = NCH'($urandom);
      step();
    end
    ch_en = '0; ch_ready = '1;
    repeat (30) step();
    chk("drained", ch_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
